// File: rtl/act_pwl_sym.sv
// Piecewise-linear sigmoid/tanh evaluator (9-point table, |x| fold with sign unfold), 3-stage valid/ready pipeline.
// Optional ACT_SAT_FLAG_EN adds the sat_flag output carrying the |x| >= 8.0 indication.
module act_pwl_sym #(
    parameter int unsigned xDW  = 16,
    parameter int unsigned yDW  = 16,
    parameter int unsigned FUNC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [xDW-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [yDW-1:0] y
`ifdef ACT_SAT_FLAG_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int unsigned AW = 17;
    localparam int unsigned KW = 3;
    localparam int unsigned FW = 11;
    localparam int unsigned EW = 15;
    localparam int unsigned PW = 26;

    // Endpoint values at |x| = 0..8 in Q1.14.
    function automatic logic [EW-1:0] ept(input logic [3:0] idx);
        logic [EW-1:0] v;
        v = '0;
        if (FUNC == 0) begin
            case (idx)
                4'd0:    v = EW'(8192);
                4'd1:    v = EW'(11978);
                4'd2:    v = EW'(14431);
                4'd3:    v = EW'(15607);
                4'd4:    v = EW'(16089);
                4'd5:    v = EW'(16274);
                4'd6:    v = EW'(16343);
                4'd7:    v = EW'(16369);
                default: v = EW'(16378);
            endcase
        end else begin
            case (idx)
                4'd0:    v = EW'(0);
                4'd1:    v = EW'(12478);
                4'd2:    v = EW'(15795);
                4'd3:    v = EW'(16303);
                4'd4:    v = EW'(16373);
                default: v = EW'(16383);
            endcase
        end
        return v;
    endfunction

    logic adv;

    logic          v1, neg1, sat1;
    logic [KW-1:0] k1;
    logic [FW-1:0] f1;

    logic                 v2, neg2, sat2;
    logic [EW-1:0]        lo2;
    logic signed [PW-1:0] p2;

    logic [AW-1:0]        xe_c, a_c;
    logic [EW-1:0]        lo_c;
    logic signed [EW-1:0] d_c;
    logic signed [11:0]   fz_c;
    logic signed [PW-1:0] p_c;
    logic [yDW-1:0]       yabs_c, y_c;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1: fold to magnitude; x = -32768 needs the 17th bit.
    always_comb begin
        xe_c = AW'(x);
        a_c  = xe_c[AW-1] ? AW'(-xe_c) : xe_c;
    end

    // Stage 2: segment base and full-precision slope product.
    always_comb begin
        lo_c = ept({1'b0, k1});
        d_c  = $signed(ept({1'b0, k1} + 4'd1) - lo_c);
        fz_c = $signed({1'b0, f1});
        p_c  = PW'(d_c) * PW'(fz_c);
    end

    // Stage 3: floor interpolation, saturate to the last endpoint, unfold by symmetry.
    always_comb begin
        yabs_c = sat2 ? yDW'(ept(4'd8)) : yDW'(lo2) + yDW'(p2 >>> FW);
        if (FUNC == 0) begin
            y_c = neg2 ? yDW'(16384) - yabs_c : yabs_c;
        end else begin
            y_c = neg2 ? yDW'(0) - yabs_c : yabs_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            neg1      <= 1'b0;
            sat1      <= 1'b0;
            k1        <= '0;
            f1        <= '0;
            v2        <= 1'b0;
            neg2      <= 1'b0;
            sat2      <= 1'b0;
            lo2       <= '0;
            p2        <= '0;
            out_valid <= 1'b0;
            y         <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            neg1      <= x[xDW-1];
            sat1      <= (a_c >= AW'(16384));
            k1        <= a_c[13:11];
            f1        <= a_c[10:0];
            v2        <= v1;
            neg2      <= neg1;
            sat2      <= sat1;
            lo2       <= lo_c;
            p2        <= p_c;
            out_valid <= v2;
            y         <= y_c;
        end
    end

`ifdef ACT_SAT_FLAG_EN
    // Flag travels with the sample and reads 0 whenever no sample is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (adv) begin
            sat_flag <= v2 & sat2;
        end
    end
`endif

endmodule

// File: tb/tb_act_pwl_sym.sv
// Directed bench for act_pwl_sym: sigmoid and tanh instances share one stimulus stream.
// With ACT_SAT_FLAG_EN defined the sat_flag outputs are checked as well.
module tb_act_pwl_sym;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] x;
    logic        in_ready_s, in_ready_t;
    logic        ov_s, ov_t;
    logic [15:0] y_s, y_t;
    logic        sf_s, sf_t;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] x;
        int          ys;
        int          yt;
        logic        sat;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    act_pwl_sym #(.xDW(16), .yDW(16), .FUNC(0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .x(x),
        .out_valid(ov_s), .out_ready(out_ready), .y(y_s)
`ifdef ACT_SAT_FLAG_EN
        , .sat_flag(sf_s)
`endif
    );

    act_pwl_sym #(.xDW(16), .yDW(16), .FUNC(1)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .x(x),
        .out_valid(ov_t), .out_ready(out_ready), .y(y_t)
`ifdef ACT_SAT_FLAG_EN
        , .sat_flag(sf_t)
`endif
    );

`ifndef ACT_SAT_FLAG_EN
    assign sf_s = 1'b0;
    assign sf_t = 1'b0;
`endif

    // Drives one sample with out_ready high and returns the observed latency and outputs.
    task automatic run_one(input logic [15:0] xv, output int lat,
                           output logic [15:0] ys, output logic [15:0] yt,
                           output logic ss, output logic st);
        @(negedge clk);
        x = xv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = 16'h0000;
        lat = 1;
        while (!ov_s && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!ov_s) lat = 99;
        ys = y_s;
        yt = y_t;
        ss = sf_s;
        st = sf_t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ov_s !== 1'b0 || ov_t !== 1'b0)
            $display("FAIL reset_out_valid: got %b/%b expected 0/0", ov_s, ov_t);
        if (ov_s !== 1'b0 || ov_t !== 1'b0) errors++;
        checks++;
        if (y_s !== 16'h0000 || y_t !== 16'h0000) begin
            $display("FAIL reset_y: got %0d/%0d expected 0/0", y_s, y_t);
            errors++;
        end
        checks++;
        if (in_ready_s !== 1'b1 || in_ready_t !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready_s, in_ready_t);
            errors++;
        end
        checks++;
        if (sf_s !== 1'b0 || sf_t !== 1'b0) begin
            $display("FAIL reset_sat_flag: got %b/%b expected 0/0", sf_s, sf_t);
            errors++;
        end
    endtask

    task automatic test_latency();
        int lat;
        logic [15:0] ys, yt;
        logic ss, st;
        run_one(16'h0000, lat, ys, yt, ss, st);
        checks++;
        if (lat !== 3) begin
            $display("FAIL latency_zero: got %0d cycles expected 3", lat);
            errors++;
        end
        checks++;
        if (ys !== 16'd8192) begin
            $display("FAIL sigmoid_zero: got %0d expected 8192", $signed(ys));
            errors++;
        end
        checks++;
        if (yt !== 16'd0) begin
            $display("FAIL tanh_zero: got %0d expected 0", $signed(yt));
            errors++;
        end
    endtask

    task automatic test_vectors();
        int lat;
        logic [15:0] ys, yt;
        logic ss, st;
        for (int i = 0; i < 10; i++) begin
            run_one(vt[i].x, lat, ys, yt, ss, st);
            checks++;
            if (lat !== 3) begin
                $display("FAIL vec_latency[%0d]: got %0d expected 3", i, lat);
                errors++;
            end
            checks++;
            if (ys !== 16'(vt[i].ys)) begin
                $display("FAIL vec_sigmoid[%0d] x=%h: got %0d expected %0d", i, vt[i].x, $signed(ys), vt[i].ys);
                errors++;
            end
            checks++;
            if (yt !== 16'(vt[i].yt)) begin
                $display("FAIL vec_tanh[%0d] x=%h: got %0d expected %0d", i, vt[i].x, $signed(yt), vt[i].yt);
                errors++;
            end
`ifdef ACT_SAT_FLAG_EN
            checks++;
            if (ss !== vt[i].sat || st !== vt[i].sat) begin
                $display("FAIL vec_sat[%0d]: got %b/%b expected %b", i, ss, st, vt[i].sat);
                errors++;
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] mv;
        logic exp_adv, acc;
        int sent, rcv;
        mv = 3'b000;
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            in_valid = (sent < 8);
            x = (sent < 8) ? vt[sent].x : 16'h0000;
            #1;
            exp_adv = !mv[2] || out_ready;
            checks++;
            if (in_ready_s !== exp_adv || in_ready_t !== exp_adv) begin
                $display("FAIL b2b_in_ready c=%0d: got %b/%b expected %b", c, in_ready_s, in_ready_t, exp_adv);
                errors++;
            end
            checks++;
            if (ov_s !== mv[2] || ov_t !== mv[2]) begin
                $display("FAIL b2b_out_valid c=%0d: got %b/%b expected %b", c, ov_s, ov_t, mv[2]);
                errors++;
            end
            if (ov_s && rcv < 8) begin
                checks++;
                if (y_s !== 16'(vt[rcv].ys) || y_t !== 16'(vt[rcv].yt)) begin
                    $display("FAIL b2b_data c=%0d idx=%0d: got %0d/%0d expected %0d/%0d",
                             c, rcv, $signed(y_s), $signed(y_t), vt[rcv].ys, vt[rcv].yt);
                    errors++;
                end
            end
            acc = in_valid && exp_adv;
            if (in_valid && in_ready_s) sent++;
            if (ov_s && out_ready) rcv++;
            if (exp_adv) mv = {mv[1:0], acc};
        end
        checks++;
        if (sent !== 8 || rcv !== 8) begin
            $display("FAIL b2b_count: got sent=%0d received=%0d expected 8/8", sent, rcv);
            errors++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = 16'h0000;
    endtask

    task automatic test_reset_midstream();
        int lat;
        logic [15:0] ys, yt;
        logic ss, st;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = vt[4 + i].x;
        end
        @(negedge clk);
        in_valid = 1'b0;
        x = 16'h0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ov_s !== 1'b0 || ov_t !== 1'b0 || y_s !== 16'h0000 || y_t !== 16'h0000) begin
            $display("FAIL midrst_clear: got valid %b/%b y %0d/%0d expected 0", ov_s, ov_t, y_s, y_t);
            errors++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ov_s !== 1'b0 || ov_t !== 1'b0) begin
                $display("FAIL midrst_flushed[%0d]: got %b/%b expected 0/0", i, ov_s, ov_t);
                errors++;
            end
        end
        run_one(16'hF800, lat, ys, yt, ss, st);
        checks++;
        if (lat !== 3) begin
            $display("FAIL midrst_latency: got %0d expected 3", lat);
            errors++;
        end
        checks++;
        if (ys !== 16'd4406 || yt !== 16'(-12478)) begin
            $display("FAIL midrst_value: got %0d/%0d expected 4406/-12478", $signed(ys), $signed(yt));
            errors++;
        end
    endtask

    initial begin
        vt[0] = '{16'h0800, 11978, 12478, 1'b0};
        vt[1] = '{16'hF800, 4406, -12478, 1'b0};
        vt[2] = '{16'h0400, 10085, 6239, 1'b0};
        vt[3] = '{16'h1000, 14431, 15795, 1'b0};
        vt[4] = '{16'h7FFF, 16378, 16383, 1'b1};
        vt[5] = '{16'h8000, 6, -16383, 1'b1};
        vt[6] = '{16'h0BB8, 13118, 14019, 1'b0};
        vt[7] = '{16'hF448, 3266, -14019, 1'b0};
        vt[8] = '{16'h3FFF, 16377, 16383, 1'b0};
        vt[9] = '{16'h4000, 16378, 16383, 1'b1};

        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
